// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, snapshot classification and key legend for the keypad scanner.
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} snap_cls_t;
    typedef struct packed {
        snap_cls_t  cls;
        logic [3:0] code;
    } snap_info_t;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_HASH = 4'd14;
    // Legend value per key index, nibble i = index i; * and # map to E and F.
    localparam logic [63:0] KEY_VALUES = 64'hDF0E_C987_B654_A321;
    function automatic logic [3:0] key_value(input logic [3:0] idx);
        return KEY_VALUES[idx*4 +: 4];
    endfunction
    // Snapshot bit col*4+row is reported as key index row*4+col.
    function automatic snap_info_t classify(input logic [15:0] snap);
        snap_info_t info;
        int n;
        n = 0;
        info.code = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                n++;
                info.code = {i[1:0], i[3:2]};
            end
        end
        info.cls = n == 0 ? CLS_NONE : n == 1 ? CLS_SINGLE : CLS_MULTI;
        return info;
    endfunction
endpackage

// File: rtl/keypad_scanner_row_sync.sv
// row_sync: two-flop synchroniser for the asynchronous keypad rows, idling high.
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta} <= '1;
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: round-robin 4x4 keypad column driver with debounced single-key press reporting.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    logic [3:0]    rows;
    logic          run;
    logic [SW-1:0] slot;
    logic [1:0]    col_idx;
    logic [15:0]   snap, snap_n;
    logic          slot_end, scan_done, fire;
    snap_info_t    info;
    state_t        state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    row_sync u_row_sync (.clk(clk), .rst(rst), .d(row_in), .q(rows));
    assign slot_end  = slot == SW'(SCAN_DIV - 1);
    assign scan_done = run && slot_end && col_idx == 2'd3;
    assign col_out   = run ? ~(4'b1 << col_idx) : 4'hF;
    always_comb begin
        snap_n = snap;
        snap_n[col_idx*4 +: 4] = ~rows;
    end
    assign info = classify(snap_n);
    // run holds the columns released until the first cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run     <= 1'b0;
            slot    <= '0;
            col_idx <= '0;
            snap    <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else if (slot_end) begin
            slot    <= '0;
            col_idx <= col_idx + 2'd1;
            snap    <= snap_n;
        end else begin
            slot <= slot + 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        fire    = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: if (info.cls == CLS_SINGLE) begin
                    cand_n  = info.code;
                    cnt_n   = CW'(1);
                    fire    = DEBOUNCE_SCANS == 1;
                    state_n = DEBOUNCE_SCANS == 1 ? PRESSED : DEBOUNCE;
                end
                DEBOUNCE: if (info.cls != CLS_SINGLE) begin
                    state_n = IDLE;
                end else if (info.code != cand) begin
                    cand_n = info.code;
                    cnt_n  = CW'(1);
                end else if (int'(cnt) + 1 >= DEBOUNCE_SCANS) begin
                    state_n = PRESSED;
                    fire    = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                PRESSED: if (info.cls == CLS_NONE) begin
                    cnt_n   = CW'(1);
                    state_n = DEBOUNCE_SCANS == 1 ? IDLE : RELEASE;
                end
                RELEASE: if (info.cls != CLS_NONE) begin
                    state_n = PRESSED;
                end else if (int'(cnt) + 1 >= DEBOUNCE_SCANS) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_valid <= fire;
            if (fire) key_code <= cand_n;
            key_held  <= state_n == PRESSED || state_n == RELEASE;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed checks of keypad_scanner against a per-scan key history model.
module tb_keypad_scanner;
    localparam int SD  = 8;
    localparam int DEB = 3;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in, col_out, key_code;
    logic        key_valid, key_held;
    logic [15:0] pressed = '0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    bit          m_held, exp_pulse;
    int          m_streak, m_none, m_last;
    logic [3:0]  m_code;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_held = 0; exp_pulse = 0; m_streak = 0; m_none = 0; m_last = 0; m_code = 4'd0;
    endtask

    // A press is a run of DEB identical single-key scans while no key is held;
    // a hold ends after a run of DEB empty scans.
    task automatic model_scan(input logic [15:0] mask);
        int n, k;
        n = $countones(mask);
        k = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        exp_pulse = 0;
        if (!m_held) begin
            if (n == 1) begin
                m_streak = (m_streak > 0 && k == m_last) ? m_streak + 1 : 1;
                m_last = k;
            end else m_streak = 0;
            if (m_streak == DEB) begin
                exp_pulse = 1; m_code = 4'(k); m_held = 1; m_streak = 0; m_none = 0;
            end
        end else begin
            m_none = (n == 0) ? m_none + 1 : 0;
            if (m_none == DEB) begin m_held = 0; m_none = 0; end
        end
    endtask

    // Entered with the next falling edge being the first cycle of a scan.
    task automatic run_scan(input logic [15:0] mask, input string tag);
        int extra;
        @(negedge clk);
        checks++; if (col_out !== 4'hE) begin errors++; $display("FAIL %s scan_align col_out=%h exp=e", tag, col_out); end
        checks++; if (key_valid !== exp_pulse) begin errors++; $display("FAIL %s key_valid got=%b exp=%b", tag, key_valid, exp_pulse); end
        if (key_valid === 1'b1) pulses++;
        checks++; if (key_held !== m_held) begin errors++; $display("FAIL %s key_held got=%b exp=%b", tag, key_held, m_held); end
        checks++; if (key_code !== m_code) begin errors++; $display("FAIL %s key_code got=%0d exp=%0d", tag, key_code, m_code); end
        pressed = mask;
        extra = 0;
        repeat (31) begin
            @(negedge clk);
            if (key_valid !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL %s stray_pulse got=%0d exp=0", tag, extra); end
        model_scan(mask);
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst = 1'b1;
        pressed = '0;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            checks++; if (col_out !== 4'hF) begin errors++; $display("FAIL reset col_out got=%h exp=f", col_out); end
            checks++; if ({key_valid, key_held, key_code} !== 6'd0) begin errors++; $display("FAIL reset outputs got=%b%b%h exp=000", key_valid, key_held, key_code); end
        end
        rst = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            exp_col = 4'b1 << ((cyc / SD) % 4);
            exp_col = ~exp_col;
            checks++; if (col_out !== exp_col) begin errors++; $display("FAIL idle_cols cyc=%0d got=%h exp=%h", cyc, col_out, exp_col); end
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", cyc, key_valid); end
        end
    endtask

    task automatic test_clean_press();
        pulses = 0;
        repeat (5) run_scan(16'h0040, "clean6");
        checks++; if (pulses != 1) begin errors++; $display("FAIL clean6 pulse_count got=%0d exp=1", pulses); end
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL clean6 code got=%0d exp=6", key_code); end
    endtask

    task automatic test_bounce();
        int extra;
        repeat (4) run_scan(16'h0000, "bounce_rel");
        extra = 0;
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            if (key_valid !== 1'b0) extra++;
            pressed = ((c / 20) % 2 == 0) ? 16'h0040 : 16'h0000;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL bounce pulses_during got=%0d exp=0", extra); end
        pulses = 0;
        repeat (4) run_scan(16'h0040, "bounce_hold");
        checks++; if (pulses != 1) begin errors++; $display("FAIL bounce pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_release_repress();
        pulses = 0;
        repeat (2) run_scan(16'h0000, "rel2");
        repeat (2) run_scan(16'h0040, "repress");
        checks++; if (pulses != 0) begin errors++; $display("FAIL repress pulse_count got=%0d exp=0", pulses); end
        repeat (4) run_scan(16'h0000, "rel3");
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rel3 key_held got=%b exp=0", key_held); end
    endtask

    task automatic test_multi();
        pulses = 0;
        repeat (6) run_scan(16'h8001, "multi");
        checks++; if (pulses != 0) begin errors++; $display("FAIL multi pulse_count got=%0d exp=0", pulses); end
        repeat (4) run_scan(16'h0001, "multi_k0");
        checks++; if (pulses != 1) begin errors++; $display("FAIL multi_k0 pulse_count got=%0d exp=1", pulses); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL multi_k0 code got=%0d exp=0", key_code); end
        repeat (4) run_scan(16'h0000, "multi_rel");
    endtask

    task automatic test_reset_mid();
        run_scan(16'h0200, "mid9");
        run_scan(16'h0200, "mid9");
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (col_out !== 4'hF) begin errors++; $display("FAIL midrst col_out got=%h exp=f", col_out); end
        checks++; if ({key_valid, key_held, key_code} !== 6'd0) begin errors++; $display("FAIL midrst outputs got=%b%b%h exp=000", key_valid, key_held, key_code); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses = 0;
        repeat (4) run_scan(16'h0200, "post9");
        checks++; if (pulses != 1) begin errors++; $display("FAIL post9 pulse_count got=%0d exp=1", pulses); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL post9 code got=%0d exp=9", key_code); end
        repeat (4) run_scan(16'h0000, "post9_rel");
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int a, b;
        for (int s = 0; s < 25; s++) begin
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            case ($urandom_range(0, 2))
                0:       mask = 16'h0000;
                1:       mask = 16'h0001 << a;
                default: mask = (16'h0001 << a) | (16'h0001 << b);
            endcase
            repeat ($urandom_range(1, 5)) run_scan(mask, "rand");
        end
        repeat (4) run_scan(16'h0000, "rand_rel");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_repress();
        test_multi();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
